game_controller_pmod_rx_multi: RTL
==================================

Name: game_controller_pmod_rx_multi

Overview:
- Parametrised receiver for the gaming PMOD serial protocol (data/clk/latch).
- Supports NUM_CTRL controllers of BITS_PER_CTRL bits each.
- Adds the following beyond plain latching:
  - frame-length checking
  - per-button press/release event pulses
  - a link watchdog that blanks stale data
- Sits between the PMOD pins and game logic; one instance replaces the driver plus per-controller decoders.

Parameters:
NUM_CTRL, 2, number of controllers in one frame (1..4)
BITS_PER_CTRL, 12, bits per controller slice
SYNC_STAGES, 2, synchroniser depth on each PMOD input (>=2)
TIMEOUT_CYCLES, 1000000, clk cycles without a valid frame before link declared lost; 0 disables watchdog

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
pmod_data  input  1  serial data, async
pmod_clk  input  1  serial clock, async; data sampled on its falling edge
pmod_latch  input  1  frame latch, async; rising edge ends a frame
buttons  output  NUM_CTRL*BITS_PER_CTRL  committed button state; slice k = [k*BITS_PER_CTRL +: BITS_PER_CTRL]; 1 = pressed
is_present  output  NUM_CTRL  1 when controller slice is not all-ones
pressed  output  NUM_CTRL*BITS_PER_CTRL  one-cycle pulse per button on 0->1 of buttons
released  output  NUM_CTRL*BITS_PER_CTRL  one-cycle pulse per button on 1->0 of buttons
frame_valid  output  1  one-cycle pulse on each accepted frame
frame_error  output  1  one-cycle pulse on each rejected frame
link_ok  output  1  1 while a valid frame arrived within TIMEOUT_CYCLES

Behaviour:
- Synchronisation: each PMOD input passes through SYNC_STAGES flops. Edges are detected between the last sync stage and a one-cycle-delayed copy of it.
- Latency: for a pin edge first sampled at clk edge N, the resulting register update occurs at edge N+SYNC_STAGES.
- Shifting: TOTAL = NUM_CTRL*BITS_PER_CTRL.
  - On a pmod_clk falling edge: shift_reg <= {shift_reg[TOTAL-2:0], data_sync}.
  - bit_cnt increments, saturating at TOTAL+1.
  - The first bit shifted in a frame ends in shift_reg[TOTAL-1].
- Latch rising edge:
  - If bit_cnt == TOTAL: commit, pulse frame_valid, clear the watchdog counter, set link_ok.
  - Otherwise: pulse frame_error; buttons, is_present and link_ok are unchanged.
  - bit_cnt is reset to 0 in both cases.
- Commit, per slice k:
  - If shift slice == all-ones: is_present[k]=0 and buttons slice=0.
  - Otherwise: is_present[k]=1 and buttons slice = shift slice.
- Simultaneous latch rise and clk fall in the same cycle:
  - Commit/check uses the pre-shift shift_reg and pre-increment bit_cnt.
  - The new bit is shifted in and bit_cnt becomes 1 (it belongs to the next frame).
- Events: on any cycle buttons changes, pressed = new & ~old and released = ~new & old, registered together with buttons (same edge). Otherwise both are 0.
- Watchdog (TIMEOUT_CYCLES>0):
  - Counter increments every cycle, saturating, and clears on accepted frame.
  - On the cycle it reaches TIMEOUT_CYCLES: link_ok<=0, buttons<=0, is_present<=0.
  - The same edge produces released pulses for every previously held button.
  - Error frames do not clear the counter.
- TIMEOUT_CYCLES=0: link_ok goes 1 on the first accepted frame and never drops except on rst.
- Reset: all outputs 0 (buttons, is_present, pressed, released, frame_valid, frame_error, link_ok); shift_reg, bit_cnt, watchdog counter and sync flops cleared.
  - Reset mid-frame discards the partial frame.
  - The first latch after reset with fewer than TOTAL bits gives frame_error.

Test Plan:
- Defaults: frame of 24 bits, ctrl1 slice=12'h000 then ctrl0 slice=12'h801 shifted MSB-first, then latch -> buttons=24'h000801, is_present=2'b11, pressed=24'h000801 for 1 cycle, frame_valid 1 cycle, latency = SYNC_STAGES edges from latch sample.
- Second frame ctrl0=12'h001 -> buttons=24'h000001, released=24'h000800 pulse, pressed=0.
- Frame with ctrl1=12'hFFF, ctrl0=12'h010 -> is_present=2'b01, buttons=24'h000010.
- Frame of 23 bits, then one of 25 bits -> frame_error pulse each, buttons unchanged, no pressed/released.
- TIMEOUT_CYCLES=100, hold ctrl0=12'h004 then stop frames -> exactly 100 cycles after the commit, link_ok=0, buttons=0, is_present=0, released=24'h000004 pulse.
- Latch rise in the same cycle as a clk fall after exactly 24 bits -> frame accepted; next frame needs only 23 further bits to be accepted. Assert rst mid-frame after 10 bits, then latch -> frame_error, all outputs 0.

Source files
------------

// File: rtl/game_controller_pmod_rx_multi.sv
// Gaming PMOD serial receiver (data/clk/latch) for NUM_CTRL controllers.
// It checks the frame length, emits per-button press/release pulses and
// blanks its outputs through a link watchdog when frames stop arriving.
module game_controller_pmod_rx_multi #(
  parameter int unsigned NUM_CTRL       = 2,
  parameter int unsigned BITS_PER_CTRL  = 12,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              pmod_data,
  input  logic                              pmod_clk,
  input  logic                              pmod_latch,
  output logic [NUM_CTRL*BITS_PER_CTRL-1:0] buttons,
  output logic [NUM_CTRL-1:0]               is_present,
  output logic [NUM_CTRL*BITS_PER_CTRL-1:0] pressed,
  output logic [NUM_CTRL*BITS_PER_CTRL-1:0] released,
  output logic                              frame_valid,
  output logic                              frame_error,
  output logic                              link_ok
);

  localparam int unsigned TOTAL  = NUM_CTRL * BITS_PER_CTRL;
  localparam int unsigned CNT_W  = $clog2(TOTAL + 2);
  localparam int unsigned WD_LIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES : 1;
  localparam int unsigned WD_W   = $clog2(WD_LIM + 1);
  localparam bit          WD_EN  = (TIMEOUT_CYCLES != 0);

  logic [SYNC_STAGES-1:0] r_data_sync;
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_latch_sync;
  logic                   r_clk_prev;
  logic                   r_latch_prev;

  logic [TOTAL-1:0]    r_shift;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [WD_W-1:0]     r_wd_cnt;
  logic [TOTAL-1:0]    r_buttons;
  logic [NUM_CTRL-1:0] r_present;
  logic [TOTAL-1:0]    r_pressed;
  logic [TOTAL-1:0]    r_released;
  logic                r_frame_valid;
  logic                r_frame_error;
  logic                r_link_ok;

  logic                w_data;
  logic                w_clk_fall;
  logic                w_latch_rise;
  logic                w_frame_ok;
  logic                w_frame_bad;
  logic                w_wd_hit;
  logic [TOTAL-1:0]    w_buttons_nxt;
  logic [NUM_CTRL-1:0] w_present_nxt;
  logic                w_link_nxt;

  assign w_data       = r_data_sync[SYNC_STAGES-1];
  assign w_clk_fall   = r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
  assign w_latch_rise = ~r_latch_prev & r_latch_sync[SYNC_STAGES-1];

  // Bring the asynchronous PMOD pins into the clk domain and keep a delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_sync  <= '0;
      r_clk_sync   <= '0;
      r_latch_sync <= '0;
      r_clk_prev   <= 1'b0;
      r_latch_prev <= 1'b0;
    end else begin
      r_data_sync  <= {r_data_sync[SYNC_STAGES-2:0], pmod_data};
      r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0], pmod_clk};
      r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], pmod_latch};
      r_clk_prev   <= r_clk_sync[SYNC_STAGES-1];
      r_latch_prev <= r_latch_sync[SYNC_STAGES-1];
    end
  end

  // Frame check, per-slice commit decode and watchdog blanking
  always_comb begin
    w_frame_ok    = w_latch_rise && (r_bit_cnt == CNT_W'(TOTAL));
    w_frame_bad   = w_latch_rise && !w_frame_ok;
    w_wd_hit      = WD_EN && !w_frame_ok && (r_wd_cnt == WD_W'(WD_LIM - 1));
    w_buttons_nxt = r_buttons;
    w_present_nxt = r_present;
    w_link_nxt    = r_link_ok;
    if (w_frame_ok) begin
      w_link_nxt = 1'b1;
      for (int unsigned k = 0; k < NUM_CTRL; k++) begin
        if (r_shift[k*BITS_PER_CTRL +: BITS_PER_CTRL] == '1) begin
          w_present_nxt[k]                             = 1'b0;
          w_buttons_nxt[k*BITS_PER_CTRL +: BITS_PER_CTRL] = '0;
        end else begin
          w_present_nxt[k]                             = 1'b1;
          w_buttons_nxt[k*BITS_PER_CTRL +: BITS_PER_CTRL] =
            r_shift[k*BITS_PER_CTRL +: BITS_PER_CTRL];
        end
      end
    end else if (w_wd_hit) begin
      w_link_nxt    = 1'b0;
      w_buttons_nxt = '0;
      w_present_nxt = '0;
    end
  end

  // Shift register and bit counter; a clk fall coinciding with a latch starts the next frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else begin
      if (w_clk_fall) begin
        r_shift <= {r_shift[TOTAL-2:0], w_data};
      end
      if (w_latch_rise) begin
        r_bit_cnt <= w_clk_fall ? CNT_W'(1) : '0;
      end else if (w_clk_fall && (r_bit_cnt != CNT_W'(TOTAL + 1))) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
    end
  end

  // Saturating link watchdog, cleared only by accepted frames
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd_cnt <= '0;
    end else if (w_frame_ok) begin
      r_wd_cnt <= '0;
    end else if (WD_EN && (r_wd_cnt != WD_W'(WD_LIM))) begin
      r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end
  end

  // Committed state with press/release events registered on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buttons     <= '0;
      r_present     <= '0;
      r_pressed     <= '0;
      r_released    <= '0;
      r_frame_valid <= 1'b0;
      r_frame_error <= 1'b0;
      r_link_ok     <= 1'b0;
    end else begin
      r_buttons     <= w_buttons_nxt;
      r_present     <= w_present_nxt;
      r_pressed     <= w_buttons_nxt & ~r_buttons;
      r_released    <= ~w_buttons_nxt & r_buttons;
      r_frame_valid <= w_frame_ok;
      r_frame_error <= w_frame_bad;
      r_link_ok     <= w_link_nxt;
    end
  end

  assign buttons     = r_buttons;
  assign is_present  = r_present;
  assign pressed     = r_pressed;
  assign released    = r_released;
  assign frame_valid = r_frame_valid;
  assign frame_error = r_frame_error;
  assign link_ok     = r_link_ok;

endmodule
